// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a valid/ready holding register.
// Start bit verified at mid-bit, data/parity/stop sampled at bit centres.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TickHalf = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 armed;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    // Two-flop synchronizer; idle-high reset value so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign busy = (state != StIdle);

    // Frame FSM, holding register and error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StIdle;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            armed       <= 1'b0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            // Host read; a completion in the same cycle overrides below.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (sample_tick) begin
                unique case (state)
                    StIdle: begin
                        if (armed && !rx_s) begin
                            state    <= StStart;
                            tick_cnt <= '0;
                            armed    <= 1'b0;
                        end else if (rx_s) begin
                            armed <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (tick_cnt == TickHalf) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= StData;
                                bit_cnt <= '0;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    StData: begin
                        if (tick_cnt == TickLast) begin
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            if (bit_cnt == BitLast) begin
`ifdef UART_RX_PARITY_EN
                                state <= StParity;
`else
                                state <= StStop;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (tick_cnt == TickLast) begin
                            par_bit  <= rx_s;
                            tick_cnt <= '0;
                            state    <= StStop;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif
                    StStop: begin
                        if (tick_cnt == TickLast) begin
                            state    <= StIdle;
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                // Bad stop bit: word dropped, holding register untouched.
                                frame_err <= 1'b1;
                                rx_valid  <= rx_valid;
                            end else begin
                                // High stop bit doubles as the idle tick that re-arms.
                                armed <= 1'b1;
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun_err <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                parity_err <= par_bit ^ (^shreg) ^ (PARITY_ODD != 0);
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked every cycle against a
// tick-offset model of the receiver, plus literal pins on key results.
module tb_uart_rx;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int PO = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    // Tick offset (from detection) at which the stop bit is sampled.
    localparam int STOP_N = OS / 2 + (DB + 1 + PEN) * OS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sample_tick = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          busy;
    logic          frame_err;
    logic          overrun_err;
    logic          parity_err;

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;
    int tick_div = 0;
    bit cmp_en = 1'b0;
    bit busy_seen = 1'b0;
    int cnt_ferr = 0;
    int cnt_oerr = 0;
    int cnt_perr = 0;

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(PO)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: frame position measured as ticks since start detection.
    logic          m_sync1 = 1'b1, m_sync2 = 1'b1;
    bit            m_active = 1'b0, m_armed = 1'b0;
    int            m_n = 0;
    logic [DB-1:0] m_word = '0;
    logic [DB-1:0] m_data = '0;
    logic          m_par = 1'b0;
    bit            m_valid = 1'b0, m_ferr = 1'b0, m_oerr = 1'b0, m_perr = 1'b0;
    logic          m_line;
    bit            m_done;
    int            m_slot;

    always @(posedge clk) begin
        m_line = m_sync2;
        m_ferr = 1'b0;
        m_oerr = 1'b0;
        m_perr = 1'b0;
        m_done = 1'b0;
        if (!reset) begin
            m_sync1 = 1'b1; m_sync2 = 1'b1;
            m_active = 1'b0; m_armed = 1'b0; m_n = 0;
            m_valid = 1'b0; m_data = '0;
        end else begin
            m_sync2 = m_sync1;
            m_sync1 = rx;
            if (sample_tick) begin
                if (!m_active) begin
                    if (m_armed && !m_line) begin
                        m_active = 1'b1; m_armed = 1'b0; m_n = 0;
                    end else if (m_line) begin
                        m_armed = 1'b1;
                    end
                end else begin
                    m_n = m_n + 1;
                    if (m_n == OS / 2) begin
                        if (m_line) m_active = 1'b0;
                    end else if (m_n > OS / 2 && (m_n - OS / 2) % OS == 0) begin
                        m_slot = (m_n - OS / 2) / OS - 1;
                        if (m_slot < DB) begin
                            m_word[m_slot] = m_line;
                        end else if (PEN == 1 && m_slot == DB) begin
                            m_par = m_line;
                        end else begin
                            m_active = 1'b0;
                            m_done = 1'b1;
                            if (!m_line) begin
                                m_ferr = 1'b1;
                            end else begin
                                m_armed = 1'b1;
                                if (PEN == 1 && (m_par != ((^m_word) ^ 1'(PO)))) m_perr = 1'b1;
                                if (!m_valid || rx_ready) begin
                                    m_data = m_word;
                                    m_valid = 1'b1;
                                end else begin
                                    m_oerr = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            if (!m_done && m_valid && rx_ready) m_valid = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rx_valid", 32'(rx_valid), 32'(m_valid));
            chk("rx_data", 32'(rx_data), 32'(m_data));
            chk("busy", 32'(busy), 32'(m_active));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun_err", 32'(overrun_err), 32'(m_oerr));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
            if (busy) busy_seen = 1'b1;
            cnt_ferr += int'(frame_err);
            cnt_oerr += int'(overrun_err);
            cnt_perr += int'(parity_err);
        end
    end

    // Tick every 4 clk; rx_ready per mode (3 = only on the predicted stop-tick cycle).
    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        sample_tick = (tick_div == 0);
        case (ready_mode)
            1:       rx_ready = 1'b1;
            2:       rx_ready = 1'($urandom_range(0, 1));
            3:       rx_ready = sample_tick && m_active && (m_n + 1 == STOP_N);
            default: rx_ready = 1'b0;
        endcase
    end

    task automatic send_bit(input logic b, input int ticks);
        rx = b;
        repeat (ticks * 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b,
                              input int stop_ticks);
        send_bit(1'b0, OS);
        for (int i = 0; i < DB; i++) send_bit(d[i], OS);
        if (PEN == 1) send_bit(par_b, OS);
        send_bit(stop_b, stop_ticks);
    endtask

    function automatic logic par_of(input logic [DB-1:0] d);
        return (^d) ^ 1'(PO);
    endfunction

    task automatic consume();
        @(posedge clk);
        ready_mode = 1;
        @(posedge clk);
        ready_mode = 0;
        @(negedge clk);
    endtask

    initial begin
        int f0, o0, p0, gap;
        logic [DB-1:0] d;
        logic pb;
        bit bad;

        @(negedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_data", 32'(rx_data), 32'd0);
        reset = 1'b1;
        send_bit(1'b1, 2 * OS);

        // 0xA5, then host read one cycle later.
        send_frame(8'hA5, 1'b1, par_of(8'hA5), OS);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_model", 32'(m_data), 32'hA5);
        chk("a5_valid", 32'(rx_valid), 32'd1);
        consume();
        chk("a5_read", 32'(rx_valid), 32'd0);

        // 3-tick low glitch.
        f0 = cnt_ferr; o0 = cnt_oerr;
        busy_seen = 1'b0;
        send_bit(1'b0, 3);
        send_bit(1'b1, 2 * OS);
        chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_errs", 32'(cnt_ferr - f0 + cnt_oerr - o0), 32'd0);

        // Bad stop bit followed by a 40-tick break, then 0x01.
        f0 = cnt_ferr;
        send_frame(8'h3C, 1'b0, par_of(8'h3C), OS + 40);
        send_bit(1'b1, 2 * OS);
        chk("ferr_count", 32'(cnt_ferr - f0), 32'd1);
        chk("ferr_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h01, 1'b1, par_of(8'h01), OS);
        chk("after_break_data", 32'(rx_data), 32'h01);
        consume();

        // Overrun: back-to-back 0x11, 0x22 with no read.
        o0 = cnt_oerr;
        send_frame(8'h11, 1'b1, par_of(8'h11), OS);
        send_frame(8'h22, 1'b1, par_of(8'h22), OS);
        send_bit(1'b1, OS);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_count", 32'(cnt_oerr - o0), 32'd1);
        consume();

        // Same, but read exactly in the completion cycle.
        o0 = cnt_oerr;
        ready_mode = 3;
        send_frame(8'h11, 1'b1, par_of(8'h11), OS);
        send_frame(8'h22, 1'b1, par_of(8'h22), OS);
        send_bit(1'b1, OS);
        ready_mode = 0;
        chk("same_cycle_data", 32'(rx_data), 32'h22);
        chk("same_cycle_valid", 32'(rx_valid), 32'd1);
        chk("same_cycle_novr", 32'(cnt_oerr - o0), 32'd0);
        consume();

        // Reset during data bit 4 of 0xFF.
        send_frame(8'h77, 1'b1, par_of(8'h77), OS);
        send_bit(1'b0, OS);
        send_bit(1'b1, 4 * OS + 8);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(rx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(rx_data), 32'd0);
        chk("midrst_errs", 32'({frame_err, overrun_err, parity_err}), 32'd0);
        reset = 1'b1;
        send_bit(1'b1, 5 * OS);
        send_frame(8'h5A, 1'b1, par_of(8'h5A), OS);
        chk("after_rst_data", 32'(rx_data), 32'h5A);
        consume();

`ifdef UART_RX_PARITY_EN
        p0 = cnt_perr;
        send_frame(8'h07, 1'b1, 1'b1, OS);
        chk("par_good_data", 32'(rx_data), 32'h07);
        chk("par_good_err", 32'(cnt_perr - p0), 32'd0);
        consume();
        send_frame(8'h07, 1'b1, 1'b0, OS);
        chk("par_bad_err", 32'(cnt_perr - p0), 32'd1);
        chk("par_bad_valid", 32'(rx_valid), 32'd1);
        consume();
`else
        p0 = cnt_perr;
        send_frame(8'h07, 1'b1, 1'b0, OS);
        chk("nopar_err", 32'(cnt_perr - p0), 32'd0);
        consume();
`endif

        // Randomized traffic with random host reads, glitches and bad stop bits.
        ready_mode = 2;
        for (int i = 0; i < 30; i++) begin
            d = DB'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            pb = par_of(d);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            if ($urandom_range(0, 4) == 0) begin
                send_bit(1'b0, $urandom_range(1, 7));
                send_bit(1'b1, OS);
            end
            send_frame(d, !bad, pb, OS);
            gap = $urandom_range(0, 2);
            if (bad && gap == 0) gap = 1;
            if (gap > 0) send_bit(1'b1, gap * OS);
        end
        ready_mode = 0;
        send_bit(1'b1, 2 * OS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
